// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divider helper used by both the RX and TX sides.
package uart_rx_deserializer_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;

    // Tick index of the mid-bit sample in the start bit, and of the full-bit
    // sample in every following bit.
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;
    localparam logic [2:0] LAST_BIT    = 3'd7;

    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, restartable
// through clear so the bit grid can be aligned to a start edge.
module baud_tick_gen #(
    parameter int unsigned DIV = 325
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver front end: 2-flop synchronizer, 16x oversampled framing FSM,
// mid-bit sampling with start-glitch rejection and stop-bit checking.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int unsigned UART_BAUD   = 9600,
    parameter int unsigned INPUT_CLOCK = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned DIV = baud_div(INPUT_CLOCK, UART_BAUD);

    logic       rx_m, rx_s;
    rx_state_t  state, state_n;
    logic [3:0] samp_cnt, samp_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] dout_n;
    logic       valid_n, ferr_n;
    logic       tick, tick_clear;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RX_IDLE;
            samp_cnt       <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state          <= state_n;
            samp_cnt       <= samp_n;
            bit_cnt        <= bit_n;
            shreg          <= shreg_n;
            data_out       <= dout_n;
            data_out_valid <= valid_n;
            frame_err      <= ferr_n;
        end
    end

    always_comb begin
        state_n    = state;
        samp_n     = samp_cnt;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        dout_n     = data_out;
        valid_n    = 1'b0;
        ferr_n     = 1'b0;
        tick_clear = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_n    = RX_START;
                    samp_n     = '0;
                    tick_clear = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (samp_cnt == MID_SAMPLE) begin
                        if (!rx_s) begin
                            state_n = RX_DATA;
                            samp_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = RX_IDLE;
                        end
                    end else begin
                        samp_n = samp_cnt + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    // samp_cnt wraps 15 -> 0, so each sample lands one bit after the last
                    samp_n = samp_cnt + 4'd1;
                    if (samp_cnt == LAST_SAMPLE) begin
                        shreg_n = {rx_s, shreg[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = RX_STOP;
                        end
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    samp_n = samp_cnt + 4'd1;
                    if (samp_cnt == LAST_SAMPLE) begin
                        if (rx_s) begin
                            dout_n  = shreg;
                            valid_n = 1'b1;
                            state_n = RX_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = RX_BREAK;
                        end
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign rx_busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: directed and randomized 8N1 frames against a frame-level
// scoreboard of expected bytes, frame errors and strobe times.
module tb_uart_rx_deserializer;

    localparam int unsigned BAUD  = 100;
    localparam int unsigned FCLK  = 3200;
    localparam int unsigned DIVB  = FCLK / (BAUD * 16);
    localparam int unsigned BIT   = 16 * DIVB;
    // start edge -> strobe: 9.5 bit times on the receiver's own grid plus 3 clk
    localparam int unsigned LAT   = (BIT * 19) / 2 + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_err;
    logic       rx_busy;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned t0;
        logic [7:0]  b;
        bit          good;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] model_dout = 8'h00;
    logic       prev_pulse = 1'b0;

    uart_rx_deserializer #(.UART_BAUD(BAUD), .INPUT_CLOCK(FCLK)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_err      (frame_err),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now; abort_after < 8 stops after that many data bits.
    task automatic send(input logic [7:0] b, input bit stop_ok, input int unsigned bitclk,
                        input int unsigned extra_low, input int unsigned abort_after);
        expq.push_back('{cyc, b, stop_ok});
        rx = 1'b0;
        wait_clk(bitclk);
        for (int i = 0; i < 8; i++) begin
            if (i == int'(abort_after)) return;
            rx = b[i];
            wait_clk(bitclk);
        end
        rx = stop_ok;
        wait_clk(bitclk);
        if (!stop_ok) begin
            wait_clk(extra_low * bitclk);
            rx = 1'b1;
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (expq.size() > 0 && n < 2 * LAT) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", expq.size(), 0);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding frame in kind,
    // byte and time; data_out must always equal the last good byte.
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            model_dout = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            chk("valid_and_ferr_exclusive", {31'd0, data_out_valid & frame_err}, 0);
            chk("pulse_one_cycle", {31'd0, prev_pulse & (data_out_valid | frame_err)}, 0);
            if (data_out_valid || frame_err) begin
                if (expq.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, data_out_valid, frame_err}, 0);
                end else begin
                    exp_t e;
                    int unsigned dt;
                    e  = expq.pop_front();
                    dt = cyc - e.t0;
                    chk("strobe_kind_valid", {31'd0, data_out_valid}, {31'd0, e.good});
                    checks++;
                    if (dt + 2 < LAT || dt > LAT + 2) begin
                        failures++;
                        $display("FAIL strobe_latency: got %0d clk expected %0d+-2", dt, LAT);
                    end
                    if (data_out_valid && e.good) model_dout = e.b;
                end
            end else if (expq.size() > 0 && cyc > expq[0].t0 + LAT + 2) begin
                chk("missing_strobe_byte", 32'hFFFF_FFFF, {24'd0, expq[0].b});
                void'(expq.pop_front());
            end
            chk("data_out_model", {24'd0, data_out}, {24'd0, model_dout});
            prev_pulse = data_out_valid | frame_err;
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int unsigned n;
        wait_clk(4);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_data_out", {24'd0, data_out}, 32'h00);
        chk("reset_valid", {31'd0, data_out_valid}, 0);
        chk("reset_ferr", {31'd0, frame_err}, 0);
        chk("reset_busy", {31'd0, rx_busy}, 0);
        wait_clk(20);

        // 1: single good frame
        send(8'hA5, 1'b1, BIT, 0, 8);
        drain();
        chk("t1_data_A5", {24'd0, data_out}, 32'hA5);
        wait_clk(20);

        // 2: start glitch rejected, then a clean frame
        rx = 1'b0;
        wait_clk(6);
        chk("t2_busy_during_glitch", {31'd0, rx_busy}, 1);
        rx = 1'b1;
        n = 0;
        while (rx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_busy_fall_20clk", {31'd0, rx_busy}, 0);
        wait_clk(20);
        send(8'h3C, 1'b1, BIT, 0, 8);
        drain();
        chk("t2_data_3C", {24'd0, data_out}, 32'h3C);
        wait_clk(20);

        // 3: framing error with line break, data_out keeps last good byte
        send(8'h3C, 1'b0, BIT, 3, 8);
        drain();
        chk("t3_data_held", {24'd0, data_out}, 32'h3C);
        wait_clk(20);
        send(8'h5A, 1'b1, BIT, 0, 8);
        drain();
        chk("t3_data_5A", {24'd0, data_out}, 32'h5A);
        wait_clk(20);

        // 4: back-to-back frames, no idle gap
        send(8'h00, 1'b1, BIT, 0, 8);
        send(8'hFF, 1'b1, BIT, 0, 8);
        send(8'h81, 1'b1, BIT, 0, 8);
        drain();
        chk("t4_data_81", {24'd0, data_out}, 32'h81);
        wait_clk(20);

        // 5: reset mid-frame abandons it
        send(8'h77, 1'b1, BIT, 0, 3);
        rx    = 1'b1;
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_reset", {31'd0, rx_busy}, 0);
        chk("t5_data_cleared", {24'd0, data_out}, 32'h00);
        wait_clk(2 * BIT);
        send(8'h81, 1'b1, BIT, 0, 8);
        drain();
        chk("t5_data_81", {24'd0, data_out}, 32'h81);
        wait_clk(20);

        // 6: line 3% slow
        send(8'hC3, 1'b1, BIT + 1, 0, 8);
        drain();
        chk("t6_data_C3", {24'd0, data_out}, 32'hC3);
        wait_clk(20);

        // randomized frames: bytes, +-3% bit period, gaps, occasional framing errors
        for (int k = 0; k < 24; k++) begin
            logic [7:0]  b;
            bit          good;
            int unsigned bc, gap;
            b    = 8'($urandom);
            bc   = $urandom_range(BIT - 1, BIT + 1);
            good = ($urandom_range(0, 7) != 0);
            gap  = $urandom_range(0, 40);
            if (gap > 0) wait_clk(gap);
            send(b, good, bc, good ? 0 : $urandom_range(1, 3), 8);
            if (!good) wait_clk(5);
        end
        drain();
        wait_clk(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
